// File: rtl/bip_pkg.sv
//------------------------------------------------------------------------------
// Module      : bip_pkg
// Description : Shared BIP definitions: default address width, program-counter
//               FSM state type and the per-cycle sequencer action type.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bip_pkg;

  // Default instruction address width, shared with imem and the control unit.
  localparam int BIP_AW = 11;

  // Program-counter FSM states.
  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } pc_state_t;

  // Action selected for an enabled RUN cycle, already priority-resolved.
  typedef enum logic [2:0] {
    ACT_HALT   = 3'd0,
    ACT_RET    = 3'd1,
    ACT_CALL   = 3'd2,
    ACT_BRANCH = 3'd3,
    ACT_INC    = 3'd4
  } pc_act_t;

  // Resolve the request strobes: Halt > Ret > Call > Branch > increment.
  function automatic pc_act_t pc_decode(input logic halt, input logic ret,
                                        input logic call, input logic branch);
    pc_act_t act;
    if (halt)        act = ACT_HALT;
    else if (ret)    act = ACT_RET;
    else if (call)   act = ACT_CALL;
    else if (branch) act = ACT_BRANCH;
    else             act = ACT_INC;
    return act;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bip_pc_seq_if.sv
//------------------------------------------------------------------------------
// Module      : bip_pc_seq_if
// Description : Control-unit <-> program-address sequencer bundle. The master
//               (control unit) drives the request strobes and observes the
//               address and status; the slave is the sequencer itself.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bip_pc_seq_if
  import bip_pkg::*;
#(
  parameter int AW = BIP_AW
) ();

  logic          En;
  logic          Branch;
  logic          BranchRel;
  logic [AW-1:0] Target;
  logic          Call;
  logic          Ret;
  logic          Halt;
  logic [AW-1:0] Addr;
  logic          Halted;
  logic          StackErr;

  modport master (
    output En, Branch, BranchRel, Target, Call, Ret, Halt,
    input  Addr, Halted, StackErr
  );

  modport slave (
    input  En, Branch, BranchRel, Target, Call, Ret, Halt,
    output Addr, Halted, StackErr
  );

endinterface

`default_nettype wire

// File: rtl/bip_pc_ras.sv
//------------------------------------------------------------------------------
// Module      : bip_pc_ras
// Description : Return-address LIFO for the BIP program sequencer. Push and
//               pop are never requested together by the parent. Overflowing
//               pushes and underflowing pops are ignored here; the parent
//               flags them.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bip_pc_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int             PW       = $clog2(DEPTH);
  localparam logic [PW:0]    FULL_CNT = (PW + 1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  count;
  logic [PW-1:0] top_idx;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // Top of stack is count-1; the low bits wrap naturally when full.
  assign top_idx = count[PW-1:0] - 1'b1;
  assign dout    = mem[top_idx];

  // Storage write on an accepted push; contents need no reset.
  always_ff @(posedge Clk) begin
    if (push && !full) begin
      mem[count[PW-1:0]] <= din;
    end
  end

  // Occupancy counter; reset empties the stack.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + 1'b1;
    end else if (pop && !empty) begin
      count <= count - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bip_pc_seq.sv
//------------------------------------------------------------------------------
// Module      : bip_pc_seq
// Description : BIP program-address sequencer. Drives the instruction-memory
//               address with stall, absolute/relative branch, halt and an
//               optional call/return stack.
//               Build option: define BIP_PC_RAS_EN to include the return-
//               address stack; otherwise Call acts as an absolute branch, Ret
//               as an increment, and StackErr is tied low.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bip_pc_seq
  import bip_pkg::*;
#(
  parameter int            AW         = BIP_AW,
  parameter logic [AW-1:0] RESET_ADDR = '0,
  parameter int            RAS_DEPTH  = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  bip_pc_seq_if.slave bus
);

  // Reject configurations outside the supported range at elaboration.
  if (AW < 4 || AW > 32 || RAS_DEPTH < 2 || RAS_DEPTH > 16 ||
      (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_param
    $error("bip_pc_seq: unsupported AW or RAS_DEPTH");
  end

  pc_state_t     state;
  logic [AW-1:0] addr;
  logic          stack_err;
  pc_act_t       act;

  logic [AW-1:0] ras_dout;
  logic          ras_full;
  logic          ras_empty;
  logic          ret_ok;

  // Priority-resolved action for this cycle; only acted on in RUN with En.
  always_comb begin
    act = pc_decode(bus.Halt, bus.Ret, bus.Call, bus.Branch);
  end

`ifdef BIP_PC_RAS_EN
  localparam bit RAS_ON = 1'b1;

  logic ras_push;
  logic ras_pop;

  assign ras_push = (state == RUN) && bus.En && (act == ACT_CALL) && !ras_full;
  assign ras_pop  = (state == RUN) && bus.En && (act == ACT_RET) && !ras_empty;

  bip_pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (AW)
  ) u_ras (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (addr + 1'b1),
    .dout  (ras_dout),
    .full  (ras_full),
    .empty (ras_empty)
  );
`else
  localparam bit RAS_ON = 1'b0;

  // No storage: the stack looks permanently empty and never full.
  assign ras_dout  = '0;
  assign ras_full  = 1'b0;
  assign ras_empty = 1'b1;
`endif

  assign ret_ok = RAS_ON && !ras_empty;

  // Program-counter FSM: one action per enabled RUN cycle, frozen when HALTED.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= RUN;
      addr      <= RESET_ADDR;
      stack_err <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.En) begin
            case (act)
              ACT_HALT: begin
                state <= HALTED;
              end
              ACT_RET: begin
                if (ret_ok) begin
                  addr <= ras_dout;
                end else begin
                  // Empty-stack return falls through to a plain increment.
                  addr <= addr + 1'b1;
                  if (RAS_ON) stack_err <= 1'b1;
                end
              end
              ACT_CALL: begin
                // The jump happens even when a full stack drops the push.
                addr <= bus.Target;
                if (RAS_ON && ras_full) stack_err <= 1'b1;
              end
              ACT_BRANCH: begin
                // Equal-width add is modulo 2^AW, so the offset's sign
                // extension is implicit.
                if (bus.BranchRel) addr <= addr + bus.Target;
                else               addr <= bus.Target;
              end
              ACT_INC: begin
                addr <= addr + 1'b1;
              end
              default: begin
                addr <= addr + 1'b1;
              end
            endcase
          end
        end
        HALTED: begin
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign bus.Addr     = addr;
  assign bus.Halted   = (state == HALTED);
  assign bus.StackErr = stack_err;

endmodule

`default_nettype wire
